// File: rtl/fwd_scoreboard_if.sv
// Issue/forwarding bundle between the EX stage and the forwarding scoreboard.
interface fwd_scoreboard_if #(
   parameter int unsigned SELW = 2
);
   logic            issue_valid_i;
   logic [4:0]      issue_rd_i;
   logic            issue_wen_i;
   logic [1:0]      issue_class_i;
   logic [4:0]      rs1_i;
   logic [4:0]      rs2_i;
   logic            flush_i;
   logic [SELW-1:0] fwd_sel_a_o;
   logic [SELW-1:0] fwd_sel_b_o;
   logic            fwd_link_a_o;
   logic            fwd_link_b_o;
   logic            stall_o;
   logic [31:0]     stall_cnt_o;

   modport master (
      output issue_valid_i, issue_rd_i, issue_wen_i, issue_class_i,
      output rs1_i, rs2_i, flush_i,
      input  fwd_sel_a_o, fwd_sel_b_o, fwd_link_a_o, fwd_link_b_o,
      input  stall_o, stall_cnt_o
   );

   modport slave (
      input  issue_valid_i, issue_rd_i, issue_wen_i, issue_class_i,
      input  rs1_i, rs2_i, flush_i,
      output fwd_sel_a_o, fwd_sel_b_o, fwd_link_a_o, fwd_link_b_o,
      output stall_o, stall_cnt_o
   );
endinterface

// File: rtl/fwd_scoreboard.sv
// Forwarding/hazard unit: shadows post-EX destination tags and picks operand sources.
// Optional stall-cycle counter enabled by defining FWD_SCOREBOARD_PERF_EN.
module fwd_scoreboard #(
   parameter int unsigned DEPTH      = 3,
   parameter int unsigned LOAD_READY = 2,
   parameter int unsigned SELW       = $clog2(DEPTH + 1)
) (
   input logic              clk_i,
   input logic              rst_i,
   fwd_scoreboard_if.slave  bus
);

   localparam logic [1:0] CLS_LOAD = 2'b01;
   localparam logic [1:0] CLS_LINK = 2'b10;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic [1:0] cls;
   } entry_t;

   // Index k-1 holds the instruction in post-EX stage k.
   entry_t e_q [DEPTH];
   entry_t e_d [DEPTH];

   logic            hit_a, hit_b;
   logic            rdy_a, rdy_b;
   logic            need_a, need_b;
   logic [SELW-1:0] k_a, k_b;
   logic [1:0]      cls_a, cls_b;
   logic            stall_c;
   logic            push_c;

   // Youngest-match search; iterating oldest to youngest lets the youngest win.
   always_comb begin
      hit_a = 1'b0;
      hit_b = 1'b0;
      k_a   = '0;
      k_b   = '0;
      cls_a = '0;
      cls_b = '0;
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
         if (e_q[k].valid && (e_q[k].rd == bus.rs1_i) && (bus.rs1_i != 5'd0)) begin
            hit_a = 1'b1;
            k_a   = SELW'(k + 1);
            cls_a = e_q[k].cls;
         end
         if (e_q[k].valid && (e_q[k].rd == bus.rs2_i) && (bus.rs2_i != 5'd0)) begin
            hit_b = 1'b1;
            k_b   = SELW'(k + 1);
            cls_b = e_q[k].cls;
         end
      end
   end

   always_comb begin
      rdy_a   = (cls_a != CLS_LOAD) || (k_a >= SELW'(LOAD_READY));
      rdy_b   = (cls_b != CLS_LOAD) || (k_b >= SELW'(LOAD_READY));
      need_a  = hit_a & ~rdy_a;
      need_b  = hit_b & ~rdy_b;
      stall_c = (need_a | need_b) & bus.issue_valid_i & ~bus.flush_i;
      push_c  = bus.issue_valid_i & bus.issue_wen_i & (bus.issue_rd_i != 5'd0)
              & ~stall_c & ~bus.flush_i;
   end

   assign bus.fwd_sel_a_o  = (hit_a & rdy_a) ? k_a : '0;
   assign bus.fwd_sel_b_o  = (hit_b & rdy_b) ? k_b : '0;
   assign bus.fwd_link_a_o = hit_a & rdy_a & (cls_a == CLS_LINK);
   assign bus.fwd_link_b_o = hit_b & rdy_b & (cls_b == CLS_LINK);
   assign bus.stall_o      = stall_c;

   // Shift pipeline; stage 1 gets the EX instruction or a bubble.
   always_comb begin
      e_d[0] = '0;
      if (push_c) begin
         e_d[0].valid = 1'b1;
         e_d[0].rd    = bus.issue_rd_i;
         e_d[0].cls   = bus.issue_class_i;
      end
      for (int k = 1; k < int'(DEPTH); k++) begin
         e_d[k] = e_q[k-1];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 0; k < int'(DEPTH); k++) begin
            e_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < int'(DEPTH); k++) begin
            e_q[k] <= e_d[k];
         end
      end
   end

`ifdef FWD_SCOREBOARD_PERF_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] stall_cnt_d;

   assign stall_cnt_d = stall_c ? (stall_cnt_q + 32'd1) : stall_cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.stall_cnt_o = stall_cnt_q;
`else
   assign bus.stall_cnt_o = '0;
`endif

endmodule
